// File: rtl/reaction_timer.sv
// Reaction-time measurement front end: pseudo-random wait, go indicator, millisecond count until press.
// Optional false-start detection is enabled with REACTION_TIMER_FALSE_START_EN.
`timescale 1ns/1ps
module reaction_timer #(
  parameter int TICK_DIV  = 50000,
  parameter int MIN_DELAY = 1000
) (
  input  logic        Clock,
  input  logic        CLR,
  input  logic        Start,
  input  logic        Button,
  output logic [12:0] Time,
  output logic        Load,
  output logic        Go,
  output logic        TooSoon
);

  localparam int            PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);
  localparam logic [12:0]   TIME_MAX  = 13'h1FFF;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GO, S_DONE} state_t;

  state_t        r_state;
  logic          r_start_d;
  logic          r_button_d;
  logic [15:0]   r_lfsr;
  logic [15:0]   r_delay;
  logic [PW-1:0] r_presc;
  logic [12:0]   r_time;
  logic          r_load;
  logic          r_go;
  logic          r_too_soon;

  logic          w_start_edge;
  logic          w_button_edge;
  logic          w_tick;
  logic          w_lfsr_fb;
  logic          w_false_start;
  logic [12:0]   w_time_inc;
  logic [15:0]   w_delay_init;

  assign w_start_edge  = Start & ~r_start_d;
  assign w_button_edge = Button & ~r_button_d;
  assign w_tick        = (r_presc == TICK_LAST);
  assign w_lfsr_fb     = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_time_inc    = (r_time == TIME_MAX) ? r_time : r_time + 13'd1;
  assign w_delay_init  = 16'(MIN_DELAY) + {5'b0, r_lfsr[10:0]};

`ifdef REACTION_TIMER_FALSE_START_EN
  assign w_false_start = (r_state == S_WAIT) & w_button_edge;
`else
  assign w_false_start = 1'b0;
`endif

  always_ff @(posedge Clock or posedge CLR) begin
    if (CLR) begin
      r_state    <= S_IDLE;
      r_start_d  <= 1'b0;
      r_button_d <= 1'b0;
      r_lfsr     <= 16'hACE1;
      r_delay    <= '0;
      r_presc    <= '0;
      r_time     <= '0;
      r_load     <= 1'b0;
      r_go       <= 1'b0;
      r_too_soon <= 1'b0;
    end else begin
      r_start_d  <= Start;
      r_button_d <= Button;
      r_lfsr     <= {r_lfsr[14:0], w_lfsr_fb};
      r_presc    <= w_tick ? '0 : r_presc + PW'(1);
      r_load     <= 1'b0;
      // Every state change below also restarts the prescaler so tick phase is relative to state entry.
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_edge) begin
            r_state    <= S_WAIT;
            r_delay    <= w_delay_init;
            r_time     <= '0;
            r_too_soon <= 1'b0;
            r_presc    <= '0;
          end
        end
        S_WAIT: begin
          if (w_false_start) begin
            r_state    <= S_DONE;
            r_time     <= TIME_MAX;
            r_too_soon <= 1'b1;
            r_load     <= 1'b1;
            r_presc    <= '0;
          end else if (w_tick) begin
            if (r_delay == 16'd0) begin
              r_state <= S_GO;
              r_go    <= 1'b1;
              r_presc <= '0;
            end else begin
              r_delay <= r_delay - 16'd1;
            end
          end
        end
        S_GO: begin
          if (w_tick) begin
            r_time <= w_time_inc;
          end
          if (w_button_edge) begin
            r_state <= S_DONE;
            r_go    <= 1'b0;
            r_load  <= 1'b1;
            r_presc <= '0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign Time    = r_time;
  assign Load    = r_load;
  assign Go      = r_go;
  assign TooSoon = r_too_soon;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: directed rounds with literal expectations plus
// randomized Start/Button/CLR traffic compared every cycle against a round-level model.
`timescale 1ns/1ps
module tb_reaction_timer;

  localparam int TICK_DIV  = 4;
  localparam int MIN_DELAY = 2;
  localparam int TMAX      = 8191;
`ifdef REACTION_TIMER_FALSE_START_EN
  localparam bit FALSE_START = 1'b1;
`else
  localparam bit FALSE_START = 1'b0;
`endif

  localparam int P_IDLE = 0;
  localparam int P_WAIT = 1;
  localparam int P_GO   = 2;
  localparam int P_DONE = 3;

  logic        Clock;
  logic        CLR;
  logic        Start;
  logic        Button;
  logic [12:0] Time;
  logic        Load;
  logic        Go;
  logic        TooSoon;

  int checks = 0;
  int errors = 0;

  reaction_timer #(.TICK_DIV(TICK_DIV), .MIN_DELAY(MIN_DELAY)) dut (
    .Clock   (Clock),
    .CLR     (CLR),
    .Start   (Start),
    .Button  (Button),
    .Time    (Time),
    .Load    (Load),
    .Go      (Go),
    .TooSoon (TooSoon)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Round-level model: k counts edges since entering the current phase; ticks fall on multiples
  // of TICK_DIV, so WAIT lasts (delay+1)*TICK_DIV edges and GO time is k/TICK_DIV, capped.
  int        m_phase, m_k, m_wait_len, m_time;
  bit        m_load, m_go, m_ts, m_sp, m_bp;
  logic [15:0] m_lfsr;

  always @(posedge Clock or posedge CLR) begin : ref_model
    int ph, k, tm, wl;
    bit ld, ts, se, be;
    if (CLR) begin
      m_phase <= P_IDLE; m_k <= 0; m_wait_len <= 0; m_time <= 0;
      m_load <= 1'b0; m_go <= 1'b0; m_ts <= 1'b0; m_sp <= 1'b0; m_bp <= 1'b0;
      m_lfsr <= 16'hACE1;
    end else begin
      se = Start && !m_sp;
      be = Button && !m_bp;
      ph = m_phase; k = m_k + 1; tm = m_time; ts = m_ts; wl = m_wait_len; ld = 1'b0;
      if ((ph == P_IDLE || ph == P_DONE) && se) begin
        wl = (MIN_DELAY + int'(m_lfsr[10:0]) + 1) * TICK_DIV;
        tm = 0; ts = 1'b0; ph = P_WAIT; k = 0;
      end else if (ph == P_WAIT) begin
        if (FALSE_START && be) begin
          ph = P_DONE; tm = TMAX; ts = 1'b1; ld = 1'b1;
        end else if (k == wl) begin
          ph = P_GO; k = 0;
        end
      end else if (ph == P_GO) begin
        tm = (k / TICK_DIV > TMAX) ? TMAX : k / TICK_DIV;
        if (be) begin
          ph = P_DONE; ld = 1'b1;
        end
      end
      m_phase <= ph; m_k <= k; m_wait_len <= wl; m_time <= tm;
      m_load <= ld; m_go <= (ph == P_GO); m_ts <= ts;
      m_sp <= Start; m_bp <= Button;
      m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  end

  always @(negedge Clock) begin
    chk("cmp_time", int'(Time), m_time);
    chk("cmp_load", int'(Load), int'(m_load));
    chk("cmp_go", int'(Go), int'(m_go));
    chk("cmp_toosoon", int'(TooSoon), int'(m_ts));
    if (m_load) $display("txn: load time=%0d toosoon=%0d (t=%0t)", m_time, m_ts, $time);
  end

  task automatic arm();
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("arm_time", int'(Time), 0);
    chk("arm_toosoon", int'(TooSoon), 0);
    chk("arm_go", int'(Go), 0);
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (Go !== 1'b1 && n < 10000) begin
      @(negedge Clock);
      n++;
    end
    if (n >= 10000) chk("go_timeout", 0, 1);
  endtask

  // Called on the negedge Go is first seen; the press is sampled k edges after Go rose.
  task automatic press_after(input int k, input int exp_time);
    for (int i = 1; i < k; i++) begin
      @(negedge Clock);
      Start = (i == 2);
    end
    Start  = 1'b0;
    Button = 1'b1;
    @(negedge Clock);
    chk("press_load", int'(Load), 1);
    chk("press_time", int'(Time), exp_time);
    chk("press_go", int'(Go), 0);
    @(negedge Clock);
    Button = 1'b0;
    chk("press_load_single", int'(Load), 0);
    chk("press_time_held", int'(Time), exp_time);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_time"}, int'(Time), 0);
    chk({tag, "_load"}, int'(Load), 0);
    chk({tag, "_go"}, int'(Go), 0);
    chk({tag, "_toosoon"}, int'(TooSoon), 0);
  endtask

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    CLR = 1'b1; Start = 1'b0; Button = 1'b0;
    repeat (3) @(negedge Clock);
    check_zero("reset");

    // First edge after reset latches the seed: low 11 bits 0x4E1 = 1249, so wait = (2+1249+1)*4.
    CLR = 1'b0; Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    chk("first_arm_time", int'(Time), 0);
    wait_go(n);
    chk("go_latency", n, 5008);
    press_after(21, 5);

    // Button in DONE is ignored.
    Button = 1'b1;
    @(negedge Clock);
    Button = 1'b0;
    chk("done_button_load", int'(Load), 0);

    // Re-arm from DONE, Start edge in WAIT ignored, then a press during WAIT.
    arm();
    repeat (2) @(negedge Clock);
    Start = 1'b1;
    @(negedge Clock);
    Start = 1'b0;
    @(negedge Clock);
    Button = 1'b1;
    @(negedge Clock);
    Button = 1'b0;
`ifdef REACTION_TIMER_FALSE_START_EN
    chk("false_start_load", int'(Load), 1);
    chk("false_start_time", int'(Time), TMAX);
    chk("false_start_flag", int'(TooSoon), 1);
    arm();
`else
    chk("wait_button_load", int'(Load), 0);
    chk("wait_button_go", int'(Go), 0);
`endif
    wait_go(n);
    press_after(16, 4);

    // Saturation: 9001 ticks into GO.
    arm();
    wait_go(n);
    press_after(36004, TMAX);

    // Reset in the middle of a GO count.
    arm();
    wait_go(n);
    repeat (10) @(negedge Clock);
    #1 CLR = 1'b1;
    #1 check_zero("midreset");
    @(negedge Clock);
    CLR = 1'b0;
    @(negedge Clock);
    chk("midreset_noload", int'(Load), 0);

    // Randomized traffic, checked by the per-cycle compare process.
    for (int i = 0; i < 12000; i++) begin
      @(negedge Clock);
      Start  = ($urandom_range(0, 299) == 0);
      Button = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 3999) == 0) begin
        #1 CLR = 1'b1;
        @(negedge Clock);
        CLR = 1'b0;
      end
    end
    Start = 1'b0; Button = 1'b0;
    @(negedge Clock);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
